// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the BCD time-of-day clock
package clock_pkg;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  // Default clk cycles per second (100 MHz reference)
  localparam int TICKS_DEFAULT = 100000000;

  // Moduli of the two-digit counters
  localparam int MOD_60 = 60;
  localparam int MOD_24 = 24;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter with programmable modulus
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] msd,
  output logic [3:0] lsd,
  output logic       carry
);

  // Digits of the terminal value MODULUS-1 (59 or 23)
  localparam bcd_t TOP_MSD = bcd_t'((MODULUS - 1) / 10);
  localparam bcd_t TOP_LSD = bcd_t'((MODULUS - 1) % 10);

  logic at_top;

  // Terminal-value detect and combinational carry out
  always_comb begin
    at_top = (msd == TOP_MSD) && (lsd == TOP_LSD);
    carry  = inc && at_top;
  end

  // Digit registers: clear wins over increment, wrap at the terminal value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msd <= '0;
      lsd <= '0;
    end else if (clr) begin
      msd <= '0;
      lsd <= '0;
    end else if (inc) begin
      if (at_top) begin
        msd <= '0;
        lsd <= '0;
      end else if (lsd == 4'd9) begin
        msd <= msd + 4'd1;
        lsd <= '0;
      end else begin
        lsd <= lsd + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_clock_counter.sv
// rtl/bcd_clock_counter.sv - HH:MM:SS BCD clock with prescaler and set mode
module bcd_clock_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       clr_sec,
  output logic [3:0] secMSB,
  output logic [3:0] secLSB,
  output logic [3:0] minMSB,
  output logic [3:0] minLSB,
  output logic [3:0] hourMSB,
  output logic [3:0] hourLSB,
  output logic       sec_tick
);

  localparam int            PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [2:0]    btn_q;
  logic [2:0]    btn_rise;
  logic          count_en;
  logic          tick_now;
  logic          sec_carry;
  logic          min_carry;
  logic          hours_carry_unused;
  logic          min_inc;
  logic          hour_inc;
  logic          sec_clr;

  // Enables, second strobe and button-edge routing into the digit counters
  always_comb begin
    count_en = run && !set_mode;
    tick_now = count_en && (presc == LAST);
    btn_rise = {inc_hour, inc_min, clr_sec} & ~btn_q;
    sec_clr  = set_mode && btn_rise[0];
    min_inc  = set_mode ? btn_rise[1] : sec_carry;
    hour_inc = set_mode ? btn_rise[2] : min_carry;
  end

  // Prescaler: forced to 0 in set mode so leaving it restarts a full second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (set_mode) begin
      presc <= '0;
    end else if (count_en) begin
      if (presc == LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Registered second pulse, aligned with the seconds digit update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_now;
    end
  end

  // Button edge-detect history, tracked in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '0;
    end else begin
      btn_q <= {inc_hour, inc_min, clr_sec};
    end
  end

  bcd_mod_counter #(.MODULUS(MOD_60)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick_now),
    .clr   (sec_clr),
    .msd   (secMSB),
    .lsd   (secLSB),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MODULUS(MOD_60)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .msd   (minMSB),
    .lsd   (minLSB),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MODULUS(MOD_24)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .msd   (hourMSB),
    .lsd   (hourLSB),
    .carry (hours_carry_unused)
  );

endmodule

// File: tb/tb_bcd_clock_counter.sv
// tb/tb_bcd_clock_counter.sv - directed self-checking bench for bcd_clock_counter
module tb_bcd_clock_counter;

  localparam int TPS = 4;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [3:0] secMSB;
  logic [3:0] secLSB;
  logic [3:0] minMSB;
  logic [3:0] minLSB;
  logic [3:0] hourMSB;
  logic [3:0] hourLSB;
  logic       sec_tick;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_clock_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .set_mode (set_mode),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .clr_sec  (clr_sec),
    .secMSB   (secMSB),
    .secLSB   (secLSB),
    .minMSB   (minMSB),
    .minLSB   (minLSB),
    .hourMSB  (hourMSB),
    .hourLSB  (hourLSB),
    .sec_tick (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time as hex-coded BCD, e.g. 24'h235958 for 23:59:58
  function automatic logic [23:0] now_time();
    return {hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1; step();
      inc_hour = 1'b0; step();
    end
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step();
      inc_min = 1'b0; step();
    end
  endtask

  // Reset, set hours/minutes in set mode, then run s whole seconds
  task automatic preset(input int h, input int m, input int s);
    run = 1'b0; set_mode = 1'b0;
    inc_hour = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    set_mode = 1'b1; step();
    press_hour(h);
    press_min(m);
    set_mode = 1'b0;
    run = 1'b1; step(s * TPS);
    run = 1'b0; step();
  endtask

  task automatic test_reset();
    run = 1'b0; set_mode = 1'b0;
    inc_hour = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (now_time() !== 24'h000000)
      $display("FAIL reset_digits: got %h expected %h", now_time(), 24'h000000);
    else pass_cnt++;
    total_cnt++;
    if (sec_tick !== 1'b0)
      $display("FAIL reset_tick: got %b expected 0", sec_tick);
    else pass_cnt++;
    step(2);
    rst_n = 1'b1; step();
  endtask

  task automatic test_count();
    logic exp_tick;
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_tick = (c == 4) || (c == 8);
      total_cnt++;
      if (sec_tick !== exp_tick)
        $display("FAIL count_tick_c%0d: got %b expected %b", c, sec_tick, exp_tick);
      else pass_cnt++;
      if (c == 4) begin
        total_cnt++;
        if (now_time() !== 24'h000001)
          $display("FAIL count_one_sec: got %h expected %h", now_time(), 24'h000001);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (now_time() !== 24'h000002)
      $display("FAIL count_two_sec: got %h expected %h", now_time(), 24'h000002);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic seen_tick;
    run = 1'b0;
    seen_tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (sec_tick) seen_tick = 1'b1;
    end
    total_cnt++;
    if (seen_tick !== 1'b0 || now_time() !== 24'h000002)
      $display("FAIL hold: got %h tick %b expected %h tick 0", now_time(), seen_tick, 24'h000002);
    else pass_cnt++;
  endtask

  task automatic test_rollover();
    preset(23, 59, 58);
    total_cnt++;
    if (now_time() !== 24'h235958)
      $display("FAIL preset_235958: got %h expected %h", now_time(), 24'h235958);
    else pass_cnt++;
    run = 1'b1;
    step(3);
    total_cnt++;
    if (sec_tick !== 1'b0 || now_time() !== 24'h235958)
      $display("FAIL roll_early: got %h tick %b expected %h tick 0", now_time(), sec_tick, 24'h235958);
    else pass_cnt++;
    step();
    total_cnt++;
    if (sec_tick !== 1'b1 || now_time() !== 24'h235959)
      $display("FAIL roll_59: got %h tick %b expected %h tick 1", now_time(), sec_tick, 24'h235959);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if (sec_tick !== 1'b1 || now_time() !== 24'h000000)
      $display("FAIL roll_wrap: got %h tick %b expected %h tick 1", now_time(), sec_tick, 24'h000000);
    else pass_cnt++;
    run = 1'b0; step();
  endtask

  task automatic test_set_wrap();
    preset(7, 59, 0);
    set_mode = 1'b1; step();
    press_min(1);
    total_cnt++;
    if (now_time() !== 24'h070000)
      $display("FAIL set_min_wrap: got %h expected %h", now_time(), 24'h070000);
    else pass_cnt++;
    press_hour(16);
    total_cnt++;
    if (now_time() !== 24'h230000)
      $display("FAIL set_hour_23: got %h expected %h", now_time(), 24'h230000);
    else pass_cnt++;
    press_hour(1);
    total_cnt++;
    if (now_time() !== 24'h000000)
      $display("FAIL set_hour_wrap: got %h expected %h", now_time(), 24'h000000);
    else pass_cnt++;
  endtask

  task automatic test_held_button();
    inc_min = 1'b1;
    step();
    total_cnt++;
    if (now_time() !== 24'h000100)
      $display("FAIL held_first: got %h expected %h", now_time(), 24'h000100);
    else pass_cnt++;
    step(9);
    total_cnt++;
    if (now_time() !== 24'h000100)
      $display("FAIL held_no_repeat: got %h expected %h", now_time(), 24'h000100);
    else pass_cnt++;
    inc_min = 1'b0; step();
  endtask

  task automatic test_ignore_outside_set();
    set_mode = 1'b0; run = 1'b0; step();
    press_min(1);
    press_hour(1);
    inc_min = 1'b1; step();
    set_mode = 1'b1; step(2);
    total_cnt++;
    if (now_time() !== 24'h000100)
      $display("FAIL ignore_edges: got %h expected %h", now_time(), 24'h000100);
    else pass_cnt++;
    inc_min = 1'b0; set_mode = 1'b0; step();
  endtask

  task automatic test_simultaneous();
    preset(5, 7, 33);
    set_mode = 1'b1; step();
    inc_hour = 1'b1; inc_min = 1'b1; clr_sec = 1'b1;
    step();
    total_cnt++;
    if (now_time() !== 24'h060800)
      $display("FAIL simultaneous: got %h expected %h", now_time(), 24'h060800);
    else pass_cnt++;
    inc_hour = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    set_mode = 1'b0; step();
  endtask

  task automatic test_async_reset();
    int wait_cycles;
    preset(12, 34, 56);
    total_cnt++;
    if (now_time() !== 24'h123456)
      $display("FAIL preset_123456: got %h expected %h", now_time(), 24'h123456);
    else pass_cnt++;
    run = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (now_time() !== 24'h000000 || sec_tick !== 1'b0)
      $display("FAIL async_reset: got %h tick %b expected %h tick 0", now_time(), sec_tick, 24'h000000);
    else pass_cnt++;
    step(2);
    rst_n = 1'b1;
    wait_cycles = 0;
    while (wait_cycles < 12 && sec_tick !== 1'b1) begin
      step();
      wait_cycles++;
    end
    total_cnt++;
    if (wait_cycles !== TPS)
      $display("FAIL post_reset_tick: got %0d cycles expected %0d", wait_cycles, TPS);
    else pass_cnt++;
    total_cnt++;
    if (now_time() !== 24'h000001)
      $display("FAIL post_reset_digits: got %h expected %h", now_time(), 24'h000001);
    else pass_cnt++;
    run = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_rollover();
    test_set_wrap();
    test_held_button();
    test_ignore_outside_set();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_clock_counter.md
BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100000000, giving the clk cycles per second; the legal range SHALL be >= 2.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port clk, input, width 1: the single clock; all state SHALL be rising-edge clocked.
REQ-004 Port rst_n, input, width 1: asynchronous active-low reset.
REQ-005 Port run, input, width 1: 1 SHALL enable timekeeping.
REQ-006 Port set_mode, input, width 1: 1 SHALL enter time-set mode.
REQ-007 Port inc_hour, input, width 1: hour-advance request, level from a debounced synchronous button.
REQ-008 Port inc_min, input, width 1: minute-advance request, level from a debounced synchronous button.
REQ-009 Port clr_sec, input, width 1: seconds-clear request, level.
REQ-010 Ports secMSB, secLSB, minMSB, minLSB, hourMSB, hourLSB, outputs, width 4 each: registered BCD digits that feed the seven-segment decoder stage directly.
REQ-011 Port sec_tick, output, width 1: one-cycle pulse per counted second.

Function
REQ-012 The prescaler SHALL have width clog2(TICKS_PER_SEC) and SHALL count 0..TICKS_PER_SEC-1 only while run=1 and set_mode=0; otherwise it SHALL hold its value.
REQ-013 sec_tick SHALL be registered and high for exactly the cycle after the prescaler reaches TICKS_PER_SEC-1; the prescaler SHALL wrap to 0 on that same edge.
REQ-014 The digits SHALL advance one second on the same edge that sets sec_tick, so new digits and sec_tick become visible together.
REQ-015 Carry chain: secLSB 9->0 SHALL increment secMSB; secMSB:secLSB 59->00 SHALL increment minutes; minutes 59->00 SHALL increment hours; hours 23->00 SHALL wrap with no further carry.
REQ-016 All six digits SHALL always hold legal values: secMSB/minMSB 0-5, hourMSB 0-2, LSBs 0-9, hours <= 23.
REQ-017 When set_mode=1, the prescaler SHALL be forced to 0, sec_tick SHALL be 0, and the second count SHALL stop.
REQ-018 Each button input SHALL be edge-detected internally: a 0->1 transition SHALL produce exactly one action, and a held level SHALL produce no repeats.
REQ-019 In set_mode=1, an inc_min rising edge SHALL advance minutes modulo 60 without carry into hours.
REQ-020 In set_mode=1, an inc_hour rising edge SHALL advance hours modulo 24.
REQ-021 In set_mode=1, a clr_sec rising edge SHALL set seconds to 00.
REQ-022 Simultaneous inc_hour, inc_min and clr_sec edges SHALL all take effect in the same cycle.
REQ-023 Button edges that occur while set_mode=0 SHALL be ignored; the edge-detect registers SHALL still track the inputs.
REQ-024 When leaving set_mode, counting SHALL restart from prescaler 0; the first sec_tick SHALL follow TICKS_PER_SEC cycles later if run=1.
REQ-025 When run=0 and set_mode=0, all digits and the prescaler SHALL hold.

Reset
REQ-026 While rst_n=0, all digits SHALL be 0 (00:00:00), the prescaler SHALL be 0, sec_tick SHALL be 0, and the edge-detect registers SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-count or mid-set SHALL abandon the operation immediately.
REQ-028 After rst_n deasserts, the first sec_tick SHALL occur TICKS_PER_SEC cycles after the first enabled edge.

Structure
REQ-029 Package clock_pkg SHALL hold the BCD digit type (4 bits), the TICKS_PER_SEC default, and the modulus constants 60 and 24.
REQ-030 A sub-module bcd_mod_counter SHALL be used: a two-digit BCD counter with parameter MODULUS, inputs inc and clr, and outputs msd, lsd and a combinational carry (inc and value = MODULUS-1).
REQ-031 bcd_mod_counter SHALL be instantiated three times (seconds mod 60, minutes mod 60, hours mod 24).

Verification (TICKS_PER_SEC=4)
REQ-032 Reset then run=1 for 8 cycles: sec_tick SHALL fire twice, 4 cycles apart, and digits SHALL read 00:00:02.
REQ-033 Preset 23:59:58 via set mode, then run 2 s: digits SHALL read 23:59:59 then 00:00:00, with sec_tick on each step.
REQ-034 set_mode=1 with minutes 59 and one inc_min pulse: minutes SHALL be 00 and hours unchanged; inc_hour at 23 SHALL give 00.
REQ-035 inc_min held high for 10 cycles in set mode: minutes SHALL advance exactly once.
REQ-036 inc_hour, inc_min and clr_sec rising in the same cycle at 05:07:33: result SHALL be 06:08:00.
REQ-037 rst_n pulsed low mid-second at 12:34:56: outputs SHALL go to 00:00:00 asynchronously with sec_tick=0, and the next tick SHALL follow 4 enabled cycles after release.
